// File: rtl/scan_xfer_receiver_if.sv
// Scanner transfer bus: 4-phase req/ack byte push from the transmitter plus the
// local consumer read port and FIFO status seen by the receiver.
interface scan_xfer_receiver_if;
    logic       transfer_req;
    logic [7:0] transfer_data;
    logic       transfer_par;
    logic       transfer_ack;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] data_count;
    logic       full;
    logic       empty;
    logic [7:0] par_err_count;

    modport master (
        output transfer_req, transfer_data, transfer_par, rd_en,
        input  transfer_ack, rd_data, rd_valid, data_count, full, empty, par_err_count
    );

    modport slave (
        input  transfer_req, transfer_data, transfer_par, rd_en,
        output transfer_ack, rd_data, rd_valid, data_count, full, empty, par_err_count
    );
endinterface

// File: rtl/scan_xfer_receiver.sv
// Receiving end of the scanner transfer: synchronised 4-phase req/ack into a byte FIFO.
// Optional XFER_PARITY_EN drops bytes with bad even parity and counts them.
module scan_xfer_receiver #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input logic                 clk,
    input logic                 rst,
    scan_xfer_receiver_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StAck,
        StReleaseWait
    } state_e;

    localparam logic [AW:0]   FullCount = DEPTH[AW:0];
    localparam logic [AW:0]   CountOne  = 1;
    localparam logic [AW-1:0] PtrOne    = 1;

    state_e      state_q;
    logic        ack_q;
    logic        req_meta_q;
    logic        req_s_q;
    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0] count_q;
    logic [AW:0] count_d;
    logic        full_q;
    logic        empty_q;
    logic [7:0]  rd_data_q;
    logic        rd_valid_q;
    logic        par_ok;
    logic        accept;
    logic        wr_fire;
    logic        rd_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_meta_q <= 1'b0;
            req_s_q    <= 1'b0;
        end else begin
            req_meta_q <= bus.transfer_req;
            req_s_q    <= req_meta_q;
        end
    end

    // Full is checked against the registered flag, so a read in the same cycle
    // cannot make room for a write until the following edge.
    always_comb begin
        accept  = (state_q == StIdle) && req_s_q && !full_q;
        wr_fire = accept && par_ok;
        rd_fire = bus.rd_en && !empty_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        ack_q   <= 1'b1;
                        state_q <= par_ok ? StAck : StReleaseWait;
                    end
                end
                StAck, StReleaseWait: begin
                    if (!req_s_q) begin
                        ack_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q] <= bus.transfer_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            full_q     <= (count_d == FullCount);
            empty_q    <= (count_d == '0);
            rd_valid_q <= rd_fire;
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (rd_fire) begin
                rd_data_q <= mem[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + PtrOne;
            end
        end
    end

`ifdef XFER_PARITY_EN
    logic       drop;
    logic [7:0] par_err_q;

    assign par_ok = ((^bus.transfer_data) == bus.transfer_par);
    assign drop   = accept && !par_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err_q <= 8'd0;
        end else if (drop && (par_err_q != 8'hFF)) begin
            par_err_q <= par_err_q + 8'd1;
        end
    end

    assign bus.par_err_count = par_err_q;
`else
    logic unused_par;

    assign par_ok            = 1'b1;
    assign unused_par        = bus.transfer_par;
    assign bus.par_err_count = 8'd0;
`endif

    assign bus.transfer_ack = ack_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.data_count   = 8'(count_q);
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;

endmodule

// File: doc/scan_xfer_receiver.md
Name: scan_xfer_receiver

Overview:
- Receiving end of the scanner transfer interface. Accepts bytes that a transmitting scanner pushes when its transfer is started.
- Uses a 4-phase req/ack handshake, buffers bytes in an internal FIFO, and exposes occupancy as data_count.
- A local consumer drains bytes through a simple read port. Sits beside the scanner in the top level, in place of the peer buffer.

Parameters:
- DEPTH, 16: FIFO entries. Power of two, 2..128.
- AW, 4: pointer width, log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- transfer_req  input  1  transmitter request, level for the 4-phase handshake.
- transfer_data  input  8  byte, stable while transfer_req=1.
- transfer_par  input  1  even-parity bit over transfer_data. Used only with XFER_PARITY_EN.
- transfer_ack  output  1  acknowledge to transmitter.
- rd_en  input  1  consumer read request, one byte per cycle.
- rd_data  output  8  read byte, registered.
- rd_valid  output  1  one-cycle pulse, rd_data valid.
- data_count  output  8  FIFO occupancy, 0..DEPTH.
- full  output  1  data_count==DEPTH.
- empty  output  1  data_count==0.
- par_err_count  output  8  dropped-byte count, saturating.

Behaviour:
- Reset (rst=0, async):
  - transfer_ack=0, rd_data=0, rd_valid=0, data_count=0, full=0, empty=1, par_err_count=0.
  - Pointers=0, synchronizer flops=0, FSM=IDLE.
  - Reset mid-handshake drops the in-flight byte and the FIFO contents.
- Synchronizer: transfer_req passes through 2 flops (req_s). transfer_data is sampled only when the FSM acts on req_s=1, which is legal because the protocol holds data stable.
- FSM (3 states):
  - IDLE: when req_s=1 and full=0, write transfer_data at this edge, set transfer_ack=1, go ACK. When req_s=1 and full=1, stay IDLE with ack=0 (backpressure); the write happens on the first edge where full=0.
  - ACK: hold ack=1. When req_s=0, set ack=0 and go IDLE.
  - RELEASE_WAIT: entered instead of ACK when a byte is dropped (parity feature only). Same exit rule as ACK.
- Latency:
  - transfer_ack rises on the 3rd rising edge after transfer_req rises (FIFO not full).
  - transfer_ack falls on the 3rd rising edge after transfer_req falls.
  - A new byte is never accepted until req_s has returned to 0.
- FIFO:
  - Write pointer and read pointer are AW bits wide and wrap DEPTH-1 -> 0.
  - data_count is tracked separately: +1 on write only, -1 on read only, unchanged on a simultaneous write and read.
  - full and empty are registered from data_count.
- Read: rd_en=1 with empty=0 latches mem[rd_ptr] into rd_data, pulses rd_valid=1 the next cycle, and advances rd_ptr. rd_en while empty is ignored: rd_valid=0, rd_data holds.
- Simultaneous read and write when full: the read proceeds, the write is held (full is evaluated before the read). When empty, the write proceeds and the read is ignored.
- Widths: data_count is zero-extended to 8 bits. par_err_count saturates at 255.

Optional Feature:
- XFER_PARITY_EN defined:
  - Computed parity = ^transfer_data. A mismatch with transfer_par drops the byte (no FIFO write) and increments par_err_count.
  - A dropped byte is still acknowledged, via RELEASE_WAIT, so the transmitter never stalls.
- XFER_PARITY_EN undefined: transfer_par is ignored, par_err_count is tied to 0, and RELEASE_WAIT is unreachable.

Test Plan:
1. Reset: hold rst=0 for 3 cycles, release with transfer_req=0 -> ack=0, empty=1, data_count=0, rd_valid=0.
2. Single transfer: data=8'hA5, req=1 -> ack=1 on the 3rd edge, data_count=1. Drop req -> ack=0 on the 3rd edge. Then rd_en=1 for 1 cycle -> rd_valid pulses, rd_data=8'hA5, empty=1.
3. Fill: 16 handshakes with data 0..15 -> data_count=16, full=1. A 17th req with data 8'h55 keeps ack=0. One read returns 8'h00; then ack rises and data_count returns to 16.
4. Wrap and order: write 20 and read 20, interleaved -> read sequence equals write sequence and pointers wrap correctly.
5. Simultaneous: with data_count=5, a write edge coincides with rd_en=1 -> data_count stays 5. rd_en on empty -> no rd_valid.
6. Parity (XFER_PARITY_EN): data=8'h03, par=1 -> ack completes, data_count unchanged, par_err_count=1. With par=0 the byte is stored.
